// File: rtl/dadda_final_adder.sv
`default_nettype none
// ============================================================================
// Module : dadda_final_adder (with HA / csa_dadda cells)
// Brief  : Two-stage valid/ready carry-propagate adder for Dadda residual rows
// Rev    : 1.0
// ============================================================================

module HA (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module csa_dadda (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module dadda_final_adder #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] row_a,
  input  logic [W-1:0] row_b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] prod,
  output logic         cout
);
  localparam int c_half = W / 2;

  logic                r_s1_valid;
  logic [c_half-1:0]   r_lo_sum;
  logic                r_c_mid;
  logic [c_half-1:0]   r_a_hi;
  logic [c_half-1:0]   r_b_hi;
  logic                r_out_valid;
  logic [W-1:0]        r_prod;
  logic                r_cout;

  logic [c_half-1:0]   w_lo_sum;
  logic [c_half-1:0]   w_lo_c;
  logic [c_half-1:0]   w_hi_sum;
  logic [c_half:0]     w_hi_c;
  logic                w_s1_load;
  logic                w_s2_load;

  // Low half: half adder on bit 0, full-adder ripple above it.
  HA u_lo_ha (
    .a (row_a[0]),
    .b (row_b[0]),
    .s (w_lo_sum[0]),
    .c (w_lo_c[0])
  );

  generate
    for (genvar i = 1; i < c_half; i++) begin : g_lo
      csa_dadda u_fa (
        .a  (row_a[i]),
        .b  (row_b[i]),
        .ci (w_lo_c[i-1]),
        .s  (w_lo_sum[i]),
        .co (w_lo_c[i])
      );
    end
  endgenerate

  assign w_hi_c[0] = r_c_mid;

  generate
    for (genvar j = 0; j < c_half; j++) begin : g_hi
      csa_dadda u_fa (
        .a  (r_a_hi[j]),
        .b  (r_b_hi[j]),
        .ci (w_hi_c[j]),
        .s  (w_hi_sum[j]),
        .co (w_hi_c[j+1])
      );
    end
  endgenerate

  // S1 may refill in the same cycle it hands off to S2, so no bubble.
  assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
  assign in_ready  = !r_s1_valid || w_s2_load;
  assign w_s1_load = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid  <= 1'b0;
      r_lo_sum    <= '0;
      r_c_mid     <= 1'b0;
      r_a_hi      <= '0;
      r_b_hi      <= '0;
      r_out_valid <= 1'b0;
      r_prod      <= '0;
      r_cout      <= 1'b0;
    end else begin
      r_s1_valid  <= w_s1_load || (r_s1_valid && !w_s2_load);
      r_out_valid <= w_s2_load || (r_out_valid && !out_ready);
      if (w_s1_load) begin
        r_lo_sum <= w_lo_sum;
        r_c_mid  <= w_lo_c[c_half-1];
        r_a_hi   <= row_a[W-1:c_half];
        r_b_hi   <= row_b[W-1:c_half];
      end
      if (w_s2_load) begin
        r_prod <= {w_hi_sum, r_lo_sum};
        r_cout <= w_hi_c[c_half];
      end
    end
  end

  assign out_valid = r_out_valid;
  assign prod      = r_prod;
  assign cout      = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_dadda_final_adder.sv
`default_nettype none
// ============================================================================
// Module : tb_dadda_final_adder
// Brief  : Directed + reduced-multiplier stimulus against an ordered scoreboard
// Rev    : 1.0
// ============================================================================

module tb_dadda_final_adder;
  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] p;
    logic         c;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] row_a = '0;
  logic [W-1:0] row_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] prod;
  logic         cout;

  int   n_vec = 0;
  int   n_bad = 0;
  exp_t sb[$];
  exp_t cur_exp;
  bit   rand_ready = 1'b0;
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_prod = '0;
  logic         prev_cout = 1'b0;

  dadda_final_adder #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .row_a     (row_a),
    .row_b     (row_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prod      (prod),
    .cout      (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W:0] act, input logic [W:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Reference reduction: partial products squeezed by 3:2 row compressors to two rows.
  task automatic reduce(input logic [7:0] a, input logic [7:0] b,
                        output logic [W-1:0] r0, output logic [W-1:0] r1);
    logic [W-1:0] q[$];
    logic [W-1:0] x, y, z;
    for (int i = 0; i < 8; i++) q.push_back(b[i] ? ({8'h00, a} << i) : '0);
    while (q.size() > 2) begin
      x = q.pop_front();
      y = q.pop_front();
      z = q.pop_front();
      q.push_back(x ^ y ^ z);
      q.push_back(((x & y) | (x & z) | (y & z)) << 1);
    end
    r0 = q[0];
    r1 = q[1];
  endtask

  // Entered and left at posedge+1.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] ep, input logic ec);
    bit done = 1'b0;
    row_a    = a;
    row_b    = b;
    cur_exp  = '{p: ep, c: ec};
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clk);
      done = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!done) check("send_timeout", 1'b0, 1'b1);
  endtask

  // Scoreboard and flow-control model, sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      prev_stall <= 1'b0;
    end else begin
      check("in_ready_model", in_ready, !(sb.size() == 2 && !out_ready));
      if (sb.size() == 2) check("full_out_valid", out_valid, 1'b1);
      if (prev_stall) begin
        check("stall_valid", out_valid, 1'b1);
        check("stall_prod", {cout, prod}, {prev_cout, prev_prod});
      end
      if (out_valid && sb.size() == 0) check("spurious_out", out_valid, 1'b0);
      if (out_valid && out_ready && sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", {cout, prod}, {e.c, e.p});
      end
      if (in_valid && in_ready) sb.push_back(cur_exp);
      prev_stall <= out_valid && !out_ready;
      prev_prod  <= prod;
      prev_cout  <= cout;
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    logic [W-1:0] r0, r1;
    logic [7:0]   a8, b8;
    logic [W:0]   s17;
    bit           seen;

    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_prod", {cout, prod}, '0);
    check("rst_in_ready", in_ready, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;

    send(16'h0000, 16'h0000, 16'h0000, 1'b0);
    send(16'h00FF, 16'h0001, 16'h0100, 1'b0);
    send(16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    send(16'h8000, 16'h8000, 16'h0000, 1'b1);
    send(16'hFE00, 16'h0001, 16'hFE01, 1'b0);
    send(16'h1234, 16'h4321, 16'h5555, 1'b0);
    repeat (4) @(posedge clk);
    #1;

    // Backpressure: four pairs against a 5-cycle stall.
    out_ready = 1'b0;
    fork
      begin
        send(16'h0001, 16'h0002, 16'h0003, 1'b0);
        send(16'h00F0, 16'h0010, 16'h0100, 1'b0);
        send(16'hAAAA, 16'h5555, 16'hFFFF, 1'b0);
        send(16'hFFFF, 16'hFFFF, 16'hFFFE, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        #2;
        check("bp_in_ready_low", in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;

    // Both stages full, consumer ready, new pair offered: accepted with no bubble.
    out_ready = 1'b0;
    send(16'h0100, 16'h0200, 16'h0300, 1'b0);
    send(16'h0400, 16'h0500, 16'h0900, 1'b0);
    out_ready = 1'b1;
    send(16'h7FFF, 16'h0001, 16'h8000, 1'b0);
    check("no_bubble_a", out_valid, 1'b1);
    @(posedge clk);
    #1;
    check("no_bubble_b", out_valid, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    // Asynchronous reset with both stages full.
    out_ready = 1'b0;
    send(16'h1111, 16'h1111, 16'h2222, 1'b0);
    send(16'h3333, 16'h3333, 16'h6666, 1'b0);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_out_valid", out_valid, 1'b0);
    check("arst_prod", {cout, prod}, '0);
    check("arst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(16'h00FF, 16'h00FF, 16'h01FE, 1'b0);
    check("lat_edge1", out_valid, 1'b0);
    @(posedge clk);
    #1;
    check("lat_edge2", out_valid, 1'b1);
    check("lat_prod", prod, 16'h01FE);
    repeat (2) @(posedge clk);
    #1;

    // Multiplier sweep through reduced rows with random consumer stalls.
    reduce(8'hFF, 8'hFF, r0, r1);
    s17 = {1'b0, r0} + {1'b0, r1};
    send(r0, r1, 16'hFE01, s17[W]);
    rand_ready = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      a8 = 8'($urandom_range(0, 255));
      b8 = 8'($urandom_range(0, 255));
      reduce(a8, b8, r0, r1);
      s17 = {1'b0, r0} + {1'b0, r1};
      send(r0, r1, 16'(a8) * 16'(b8), s17[W]);
    end
    rand_ready = 1'b0;
    #1;
    out_ready = 1'b1;

    seen = 1'b0;
    for (int t = 0; t < 50 && !seen; t++) begin
      @(posedge clk);
      #1;
      seen = (sb.size() == 0);
    end
    if (!seen) check("drain_timeout", 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("idle_out_valid", out_valid, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
